ctrl_bubble_reg: RTL and testbench
==================================

Name: ctrl_bubble_reg

Overview:
Parametrised ID/EX control pipeline register with built-in hazard handling. It latches the decoded control bundle each cycle and detects load-use hazards against the instruction it holds. It inserts NOP control bubbles for a configurable number of cycles on load-use stalls and on branch/jump flushes. It supports a global hold and keeps a saturating bubble counter. It supersedes the purely combinational control-zeroing mux in front of the ID/EX register.

Parameters:
CTRL_W, 16, width of the control bundle (Wbsel 2 + MemRw 1 + ALUsel 4 + Asel 1 + Bsel 1 + Rsel 3 + Wsel 2 + Regwrite 1 + PCsel 1)
NOP_CTRL, {CTRL_W{1'b0}}, control value injected as a bubble
REG_AW, 5, register-address width
LOAD_STALL_CYCLES, 1, bubbles per load-use hazard (>=1)
FLUSH_CYCLES, 2, bubbles per flush (>=1)
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
hold_in  in  1  global freeze (memory wait)
flush_in  in  1  branch/jump taken, resolved in EX
ctrl_in  in  CTRL_W  decoded ID control bundle
rd_in  in  REG_AW  ID destination register
is_load_in  in  1  ID instruction is a load
rs1_in, rs2_in  in  REG_AW  ID source registers
rs1_used_in, rs2_used_in  in  1  source actually read
ctrl_out  out  CTRL_W  registered EX control bundle
ex_rd_out  out  REG_AW  registered EX rd
ex_is_load_out  out  1  registered EX load flag
stall_out  out  1  combinational; freezes PC and IF/ID
busy_out  out  1  state != RUN
bubble_cnt_out  out  CNT_W  saturating count of injected bubbles

Behaviour:
- Reset (async): ctrl_out=NOP_CTRL, ex_rd_out=0, ex_is_load_out=0, state=RUN, counter=0, bubble_cnt_out=0. stall_out=0 and busy_out=0 while in reset.
- hazard = (state==RUN) & ex_is_load_out & (ex_rd_out!=0) & ((rs1_used_in & rs1_in==ex_rd_out) | (rs2_used_in & rs2_in==ex_rd_out)).
- FSM states: RUN, STALL, FLUSH. cnt is a down-counter.
- Priority at each edge: rst > hold_in > flush_in > hazard/STALL > normal.
- hold_in=1:
  - All registers, state, cnt and bubble_cnt keep their values.
  - stall_out = (hazard | state==STALL) & ~flush_in.
  - flush_in is not latched. The EX stage must keep flush_in asserted until hold drops.
- flush_in=1 (any state): register NOP; ex_rd=0; ex_is_load=0.
  - If FLUSH_CYCLES>1: state<=FLUSH, cnt<=FLUSH_CYCLES-2.
  - Otherwise state stays/returns to RUN.
  - stall_out=0, so the PC loads the target.
  - An active STALL is aborted.
- FLUSH state: register NOP each edge and stall_out=0. When cnt==0, go to RUN; otherwise decrement.
- hazard in RUN: stall_out=1 and register NOP (ex_rd=0, is_load=0).
  - If LOAD_STALL_CYCLES>1: state<=STALL, cnt<=LOAD_STALL_CYCLES-2.
- STALL state: stall_out=1 and register NOP. When cnt==0, go to RUN; otherwise decrement.
  - The hazard is not re-evaluated in STALL because ex_is_load is already 0.
- Normal (RUN, no hazard, no flush): ctrl_out<=ctrl_in, ex_rd_out<=rd_in, ex_is_load_out<=is_load_in; stall_out=0.
- Bubble count: bubble_cnt increments by 1 on every non-held edge that registers a NOP due to flush, FLUSH, hazard or STALL. It saturates at all-ones with no wrap.
- busy_out = (state!=RUN).
- Latency: one cycle from ctrl_in to ctrl_out.
- A new hazard is evaluated on the first RUN cycle after FLUSH or STALL.

Test Plan:
- Reset mid-operation: enter FLUSH, assert rst asynchronously → ctrl_out=0, busy_out=0, bubble_cnt_out=0 immediately, without waiting for clk.
- Normal flow: ctrl_in=16'hA5C3, no hazards → ctrl_out=16'hA5C3 one edge later, stall_out=0, bubble_cnt_out unchanged.
- Load-use: EX holds a load with rd=5; ID has rs2=5, rs2_used=1 → stall_out=1 for 1 cycle, ctrl_out=0 for 1 cycle, then ID ctrl passes, bubble_cnt_out=1. Repeat with rd=0 → no stall.
- Flush: flush_in pulsed 1 cycle with FLUSH_CYCLES=2 → ctrl_out=0 for 2 edges, busy_out=1 for 1 cycle, stall_out=0 throughout, bubble_cnt_out+=2.
- Flush during STALL (LOAD_STALL_CYCLES=3): flush_in in the 2nd stall cycle → stall_out drops that cycle, FLUSH sequence follows, total bubbles = 1 + 2.
- Hold + saturation: hold_in=1 for 4 cycles during FLUSH → all outputs frozen. Set CNT_W=2 and inject 5 bubbles → bubble_cnt_out=3.

Source files
------------

// File: rtl/ctrl_bubble_reg.sv
// ID/EX control pipeline register with load-use stall and branch flush bubble insertion.
// Holds the EX control bundle, detects load-use hazards and counts injected bubbles.
module ctrl_bubble_reg #(
    parameter int                CTRL_W            = 16,
    parameter logic [CTRL_W-1:0] NOP_CTRL          = {CTRL_W{1'b0}},
    parameter int                REG_AW            = 5,
    parameter int                LOAD_STALL_CYCLES = 1,
    parameter int                FLUSH_CYCLES      = 2,
    parameter int                CNT_W             = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_in,
    input  logic              flush_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              is_load_in,
    input  logic [REG_AW-1:0] rs1_in,
    input  logic [REG_AW-1:0] rs2_in,
    input  logic              rs1_used_in,
    input  logic              rs2_used_in,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [REG_AW-1:0] ex_rd_out,
    output logic              ex_is_load_out,
    output logic              stall_out,
    output logic              busy_out,
    output logic [CNT_W-1:0]  bubble_cnt_out
);

    localparam int CYC_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int DC_W    = (CYC_MAX > 2) ? $clog2(CYC_MAX - 1) : 1;

    localparam logic [DC_W-1:0] DC_ZERO    = DC_W'(0);
    localparam logic [DC_W-1:0] DC_ONE     = DC_W'(1);
    localparam logic [DC_W-1:0] STALL_INIT = (LOAD_STALL_CYCLES > 1) ? DC_W'(LOAD_STALL_CYCLES - 2) : DC_W'(0);
    localparam logic [DC_W-1:0] FLUSH_INIT = (FLUSH_CYCLES > 1) ? DC_W'(FLUSH_CYCLES - 2) : DC_W'(0);
    localparam logic [CNT_W-1:0] BCNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [DC_W-1:0]     cnt_r, cnt_s;
    logic [CTRL_W-1:0]   ctrl_r, ctrl_s;
    logic [REG_AW-1:0]   ex_rd_r, ex_rd_s;
    logic                ex_is_load_r, ex_is_load_s;
    logic [CNT_W-1:0]    bubble_cnt_r, bubble_cnt_s;
    logic                bubble_s;
    logic                hazard_s;
    logic                rs1_hit_s, rs2_hit_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : (v + BCNT_ONE);
    endfunction

    // Load-use hazard between the instruction in ID and the load held in EX.
    always_comb begin
        rs1_hit_s = rs1_used_in & (rs1_in == ex_rd_r);
        rs2_hit_s = rs2_used_in & (rs2_in == ex_rd_r);
        hazard_s  = (state_r == ST_RUN) & ex_is_load_r & (ex_rd_r != {REG_AW{1'b0}})
                    & (rs1_hit_s | rs2_hit_s);
    end

    // State and pipeline register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_RUN;
            cnt_r        <= DC_ZERO;
            ctrl_r       <= NOP_CTRL;
            ex_rd_r      <= {REG_AW{1'b0}};
            ex_is_load_r <= 1'b0;
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            ctrl_r       <= ctrl_s;
            ex_rd_r      <= ex_rd_s;
            ex_is_load_r <= ex_is_load_s;
            bubble_cnt_r <= bubble_cnt_s;
        end
    end

    // Next-state: hold freezes everything, flush beats hazard, bubbles replace the ID bundle.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        ctrl_s       = ctrl_r;
        ex_rd_s      = ex_rd_r;
        ex_is_load_s = ex_is_load_r;
        bubble_s     = 1'b0;
        if (hold_in) begin
            bubble_s = 1'b0;
        end else if (flush_in) begin
            bubble_s = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_s = ST_FLUSH;
                cnt_s   = FLUSH_INIT;
            end else begin
                state_s = ST_RUN;
                cnt_s   = DC_ZERO;
            end
        end else begin
            case (state_r)
                ST_STALL, ST_FLUSH: begin
                    bubble_s = 1'b1;
                    if (cnt_r == DC_ZERO) begin
                        state_s = ST_RUN;
                    end else begin
                        cnt_s = cnt_r - DC_ONE;
                    end
                end
                ST_RUN: begin
                    if (hazard_s) begin
                        bubble_s = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_s = ST_STALL;
                            cnt_s   = STALL_INIT;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        ctrl_s       = ctrl_in;
                        ex_rd_s      = rd_in;
                        ex_is_load_s = is_load_in;
                    end
                end
                default: begin
                    bubble_s = 1'b1;
                    state_s  = ST_RUN;
                    cnt_s    = DC_ZERO;
                end
            endcase
        end
        if (bubble_s) begin
            ctrl_s       = NOP_CTRL;
            ex_rd_s      = {REG_AW{1'b0}};
            ex_is_load_s = 1'b0;
            bubble_cnt_s = sat_inc(bubble_cnt_r);
        end else begin
            bubble_cnt_s = bubble_cnt_r;
        end
    end

    // Outputs: stall is combinational so the PC/IF-ID freeze lands in the same cycle.
    always_comb begin
        stall_out      = (hazard_s | (state_r == ST_STALL)) & ~flush_in;
        busy_out       = (state_r != ST_RUN);
        ctrl_out       = ctrl_r;
        ex_rd_out      = ex_rd_r;
        ex_is_load_out = ex_is_load_r;
        bubble_cnt_out = bubble_cnt_r;
    end

endmodule

// File: tb/tb_ctrl_bubble_reg.sv
// Self-checking bench for ctrl_bubble_reg: table vectors plus hand sequences on
// three parameterisations sharing one set of stimulus inputs.
module tb_ctrl_bubble_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold, flush, is_load, rs1u, rs2u;
    logic [15:0] ctrl_in;
    logic [4:0]  rd, rs1, rs2;

    logic [15:0] a_ctrl, b_ctrl, c_ctrl;
    logic [4:0]  a_rd, b_rd, c_rd;
    logic        a_ld, b_ld, c_ld, a_st, b_st, c_st, a_bz, b_bz, c_bz;
    logic [15:0] a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    always #5 clk = ~clk;

    ctrl_bubble_reg dut_a (
        .clk(clk), .rst(rst), .hold_in(hold), .flush_in(flush), .ctrl_in(ctrl_in),
        .rd_in(rd), .is_load_in(is_load), .rs1_in(rs1), .rs2_in(rs2),
        .rs1_used_in(rs1u), .rs2_used_in(rs2u), .ctrl_out(a_ctrl), .ex_rd_out(a_rd),
        .ex_is_load_out(a_ld), .stall_out(a_st), .busy_out(a_bz), .bubble_cnt_out(a_cnt));

    ctrl_bubble_reg #(.LOAD_STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .hold_in(hold), .flush_in(flush), .ctrl_in(ctrl_in),
        .rd_in(rd), .is_load_in(is_load), .rs1_in(rs1), .rs2_in(rs2),
        .rs1_used_in(rs1u), .rs2_used_in(rs2u), .ctrl_out(b_ctrl), .ex_rd_out(b_rd),
        .ex_is_load_out(b_ld), .stall_out(b_st), .busy_out(b_bz), .bubble_cnt_out(b_cnt));

    ctrl_bubble_reg #(.CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .hold_in(hold), .flush_in(flush), .ctrl_in(ctrl_in),
        .rd_in(rd), .is_load_in(is_load), .rs1_in(rs1), .rs2_in(rs2),
        .rs1_used_in(rs1u), .rs2_used_in(rs2u), .ctrl_out(c_ctrl), .ex_rd_out(c_rd),
        .ex_is_load_out(c_ld), .stall_out(c_st), .busy_out(c_bz), .bubble_cnt_out(c_cnt));

    int          sel;
    logic [15:0] s_ctrl, s_cnt;
    logic [4:0]  s_rd;
    logic        s_ld, s_st, s_bz;

    always_comb begin
        case (sel)
            0: begin s_ctrl = a_ctrl; s_rd = a_rd; s_ld = a_ld; s_st = a_st; s_bz = a_bz; s_cnt = a_cnt; end
            1: begin s_ctrl = b_ctrl; s_rd = b_rd; s_ld = b_ld; s_st = b_st; s_bz = b_bz; s_cnt = b_cnt; end
            default: begin
                s_ctrl = c_ctrl; s_rd = c_rd; s_ld = c_ld; s_st = c_st; s_bz = c_bz; s_cnt = {14'd0, c_cnt};
            end
        endcase
    end

    typedef struct {
        logic        h, f;
        logic [15:0] c;
        logic [4:0]  d;
        logic        l;
        logic [4:0]  a, b;
        logic        au, bu;
        logic        es;
        logic [15:0] ec;
        logic [4:0]  ed;
        logic        el, eb;
        logic [15:0] en;
    } vec_t;

    vec_t tbl[26];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic h, f, input logic [15:0] c, input logic [4:0] d,
                                input logic l, input logic [4:0] a, b, input logic au, bu,
                                input logic es, input logic [15:0] ec, input logic [4:0] ed,
                                input logic el, eb, input logic [15:0] en);
        vec_t v;
        v.h = h; v.f = f; v.c = c; v.d = d; v.l = l; v.a = a; v.b = b; v.au = au; v.bu = bu;
        v.es = es; v.ec = ec; v.ed = ed; v.el = el; v.eb = eb; v.en = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle: stall sampled mid-cycle, registered outputs sampled after the edge.
    task automatic run_vec(input string tag, input vec_t v);
        vec_t e;
        logic st;
        hold = v.h; flush = v.f; ctrl_in = v.c; rd = v.d; is_load = v.l;
        rs1 = v.a; rs2 = v.b; rs1u = v.au; rs2u = v.bu;
        exp_q.push_back(v);
        @(negedge clk);
        st = s_st;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".stall"}, {31'd0, st}, {31'd0, e.es});
        chk({tag, ".ctrl"}, {16'd0, s_ctrl}, {16'd0, e.ec});
        chk({tag, ".rd"}, {27'd0, s_rd}, {27'd0, e.ed});
        chk({tag, ".ld"}, {31'd0, s_ld}, {31'd0, e.el});
        chk({tag, ".busy"}, {31'd0, s_bz}, {31'd0, e.eb});
        chk({tag, ".bcnt"}, {16'd0, s_cnt}, {16'd0, e.en});
    endtask

    task automatic zero_inputs();
        hold = 1'b0; flush = 1'b0; ctrl_in = 16'h0000; rd = 5'd0; is_load = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rs1u = 1'b0; rs2u = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        sel = 0;
        zero_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst.ctrl", {16'd0, a_ctrl}, 32'h0);
        chk("rst.rd", {27'd0, a_rd}, 32'h0);
        chk("rst.ld", {31'd0, a_ld}, 32'h0);
        chk("rst.stall", {31'd0, a_st}, 32'h0);
        chk("rst.busy", {31'd0, a_bz}, 32'h0);
        chk("rst.bcnt", {16'd0, a_cnt}, 32'h0);
        do_reset();

        tbl[0]  = mk(1'b0,1'b0,16'hA5C3,5'd3,1'b0,5'd1,5'd2,1'b0,1'b0, 1'b0,16'hA5C3,5'd3,1'b0,1'b0,16'd0);
        tbl[1]  = mk(1'b0,1'b0,16'h1234,5'd5,1'b1,5'd3,5'd0,1'b1,1'b0, 1'b0,16'h1234,5'd5,1'b1,1'b0,16'd0);
        tbl[2]  = mk(1'b0,1'b0,16'hBEEF,5'd7,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b1,16'h0000,5'd0,1'b0,1'b0,16'd1);
        tbl[3]  = mk(1'b0,1'b0,16'hBEEF,5'd7,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b0,16'hBEEF,5'd7,1'b0,1'b0,16'd1);
        tbl[4]  = mk(1'b0,1'b0,16'h0F0F,5'd0,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0F0F,5'd0,1'b1,1'b0,16'd1);
        tbl[5]  = mk(1'b0,1'b0,16'h3333,5'd4,1'b0,5'd0,5'd0,1'b1,1'b1, 1'b0,16'h3333,5'd4,1'b0,1'b0,16'd1);
        tbl[6]  = mk(1'b0,1'b1,16'h5555,5'd6,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd2);
        tbl[7]  = mk(1'b0,1'b0,16'h6666,5'd2,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b0,16'd3);
        tbl[8]  = mk(1'b0,1'b0,16'h7777,5'd1,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h7777,5'd1,1'b0,1'b0,16'd3);
        tbl[9]  = mk(1'b0,1'b1,16'h8888,5'd1,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd4);
        for (int i = 10; i < 14; i++)
            tbl[i] = mk(1'b1,1'b0,16'h9999,5'd9,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd4);
        tbl[14] = mk(1'b0,1'b0,16'h9999,5'd9,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b0,16'd5);
        tbl[15] = mk(1'b0,1'b0,16'h9999,5'd9,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h9999,5'd9,1'b1,1'b0,16'd5);
        tbl[16] = mk(1'b1,1'b0,16'hABCD,5'd8,1'b0,5'd9,5'd0,1'b1,1'b0, 1'b1,16'h9999,5'd9,1'b1,1'b0,16'd5);
        tbl[17] = mk(1'b1,1'b1,16'hABCD,5'd8,1'b0,5'd9,5'd0,1'b1,1'b0, 1'b0,16'h9999,5'd9,1'b1,1'b0,16'd5);
        tbl[18] = mk(1'b0,1'b1,16'hABCD,5'd8,1'b0,5'd9,5'd0,1'b1,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd6);
        tbl[19] = mk(1'b0,1'b0,16'hABCD,5'd8,1'b0,5'd9,5'd0,1'b1,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b0,16'd7);
        tbl[20] = mk(1'b0,1'b0,16'hABCD,5'd8,1'b0,5'd9,5'd0,1'b1,1'b0, 1'b0,16'hABCD,5'd8,1'b0,1'b0,16'd7);
        tbl[21] = mk(1'b0,1'b0,16'h1357,5'd10,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h1357,5'd10,1'b1,1'b0,16'd7);
        tbl[22] = mk(1'b0,1'b0,16'h2468,5'd11,1'b0,5'd10,5'd10,1'b1,1'b0, 1'b1,16'h0000,5'd0,1'b0,1'b0,16'd8);
        tbl[23] = mk(1'b0,1'b0,16'h2468,5'd11,1'b0,5'd10,5'd10,1'b1,1'b0, 1'b0,16'h2468,5'd11,1'b0,1'b0,16'd8);
        tbl[24] = mk(1'b0,1'b0,16'h1111,5'd12,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h1111,5'd12,1'b1,1'b0,16'd8);
        tbl[25] = mk(1'b0,1'b0,16'h2222,5'd13,1'b0,5'd12,5'd12,1'b0,1'b0, 1'b0,16'h2222,5'd13,1'b0,1'b0,16'd8);

        for (int i = 0; i < 26; i++)
            run_vec($sformatf("v%0d", i), tbl[i]);

        // Asynchronous reset while FLUSH is active, checked well before the next edge.
        run_vec("arst.pre", mk(1'b0,1'b1,16'h4444,5'd3,1'b0,5'd0,5'd0,1'b0,1'b0,
                               1'b0,16'h0000,5'd0,1'b0,1'b1,16'd9));
        #2 rst = 1'b1;
        #1;
        chk("arst.ctrl", {16'd0, a_ctrl}, 32'h0);
        chk("arst.busy", {31'd0, a_bz}, 32'h0);
        chk("arst.bcnt", {16'd0, a_cnt}, 32'h0);
        chk("arst.stall", {31'd0, a_st}, 32'h0);
        do_reset();

        // Three-cycle load-use stall, then a flush that aborts the stall.
        sel = 1;
        do_reset();
        run_vec("b0", mk(1'b0,1'b0,16'h1111,5'd5,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h1111,5'd5,1'b1,1'b0,16'd0));
        run_vec("b1", mk(1'b0,1'b0,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b1,16'h0000,5'd0,1'b0,1'b1,16'd1));
        run_vec("b2", mk(1'b0,1'b0,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b1,16'h0000,5'd0,1'b0,1'b1,16'd2));
        run_vec("b3", mk(1'b0,1'b0,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b1,16'h0000,5'd0,1'b0,1'b0,16'd3));
        run_vec("b4", mk(1'b0,1'b0,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b0,16'h2222,5'd6,1'b0,1'b0,16'd3));
        run_vec("b5", mk(1'b0,1'b0,16'h1111,5'd5,1'b1,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h1111,5'd5,1'b1,1'b0,16'd3));
        run_vec("b6", mk(1'b0,1'b0,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b1,16'h0000,5'd0,1'b0,1'b1,16'd4));
        run_vec("b7", mk(1'b0,1'b1,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd5));
        run_vec("b8", mk(1'b0,1'b0,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b0,16'h0000,5'd0,1'b0,1'b0,16'd6));
        run_vec("b9", mk(1'b0,1'b0,16'h2222,5'd6,1'b0,5'd0,5'd5,1'b0,1'b1, 1'b0,16'h2222,5'd6,1'b0,1'b0,16'd6));

        // Two-bit bubble counter saturates at 3 after five bubbles.
        sel = 2;
        do_reset();
        run_vec("c0", mk(1'b0,1'b1,16'h0001,5'd1,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd1));
        run_vec("c1", mk(1'b0,1'b0,16'h0001,5'd1,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b0,16'd2));
        run_vec("c2", mk(1'b0,1'b1,16'h0001,5'd1,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd3));
        run_vec("c3", mk(1'b0,1'b0,16'h0001,5'd1,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b0,16'd3));
        run_vec("c4", mk(1'b0,1'b1,16'h0001,5'd1,1'b0,5'd0,5'd0,1'b0,1'b0, 1'b0,16'h0000,5'd0,1'b0,1'b1,16'd3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
